coax_rx_ctrl: RTL and testbench

Sequencing and buffering controller for the coax receiver (coax_rx) in the interface2 RTL. It owns the receiver's reset line and holds the receiver off while disabled or while the transmitter drives the line. It recovers the receiver after errors and packs received 10-bit words into a FIFO, terminating each frame with a tagged marker for the host-side reader.

---
 rtl/coax_rx_ctrl_pkg.sv | 24 ++
 rtl/coax_fifo.sv | 49 ++++
 rtl/coax_rx_ctrl.sv | 152 +++++++++++++++
 tb/tb_coax_rx_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coax_rx_ctrl_pkg.sv
// rtl/coax_rx_ctrl_pkg.sv - shared entry type codes, defaults and FSM states for the coax receive path
package coax_rx_ctrl_pkg;

   localparam logic [1:0] TYPE_DATA    = 2'b00;
   localparam logic [1:0] TYPE_EOF     = 2'b01;
   localparam logic [1:0] TYPE_ERROR   = 2'b10;
   localparam logic [1:0] TYPE_OVF_EOF = 2'b11;

   localparam logic [9:0] ABORT_CODE_DEFAULT = 10'h200;
   localparam logic [9:0] WORD_COUNT_MAX     = 10'h3FF;

   typedef enum logic [2:0] {
      ST_DISABLED,
      ST_RESETTING,
      ST_IDLE,
      ST_RECEIVING,
      ST_TERMINATE
   } state_t;

   function automatic logic [9:0] sat_inc(input logic [9:0] value);
      return (value == WORD_COUNT_MAX) ? value : value + 10'd1;
   endfunction

endpackage

// File: rtl/coax_fifo.sv
// rtl/coax_fifo.sv - synchronous first-word-fall-through FIFO; caller must not push when full
module coax_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       data_in,
   output logic [WIDTH-1:0]       data_out,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_pop;

   assign empty    = (count == '0);
   assign do_pop   = pop && !empty;
   assign data_out = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= data_in;
   end

endmodule

// File: rtl/coax_rx_ctrl.sv
// rtl/coax_rx_ctrl.sv - coax receiver sequencing, error recovery and tagged receive FIFO packing
module coax_rx_ctrl
   import coax_rx_ctrl_pkg::*;
#(
   parameter int         DEPTH        = 16,
   parameter int         RESET_CYCLES = 4,
   parameter logic [9:0] ABORT_CODE   = ABORT_CODE_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic                   tx_active,
   output logic                   rx_reset,
   input  logic                   rx_active,
   input  logic                   rx_error,
   input  logic                   rx_strobe,
   input  logic [9:0]             rx_data,
   output logic [11:0]            out_data,
   output logic                   out_valid,
   input  logic                   out_read,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   overflow,
   input  logic                   overflow_clear
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int RW = $clog2(RESET_CYCLES + 1);

   state_t          state, next_state;
   logic [RW-1:0]   rst_cnt;
   logic [9:0]      word_cnt;
   logic            frame_lost;
   logic            lockout, start_frame, count_inc;
   logic            push_req, push_data, accept, drop, fifo_empty;
   logic [11:0]     push_entry;

   assign lockout = !enable || tx_active;

   always_comb begin
      next_state  = state;
      rx_reset    = 1'b1;
      push_req    = 1'b0;
      push_data   = 1'b0;
      push_entry  = '0;
      start_frame = 1'b0;
      count_inc   = 1'b0;
      case (state)
         ST_DISABLED: begin
            if (!lockout)
               next_state = ST_RESETTING;
         end
         ST_RESETTING: begin
            if (lockout)
               next_state = ST_DISABLED;
            else if (rst_cnt == '0)
               next_state = ST_IDLE;
         end
         ST_IDLE: begin
            rx_reset = 1'b0;
            if (lockout) begin
               next_state = ST_DISABLED;
            end else if (rx_error) begin
               push_req   = 1'b1;
               push_entry = {TYPE_ERROR, rx_data};
               next_state = ST_RESETTING;
            end else if (rx_active) begin
               start_frame = 1'b1;
               next_state  = ST_RECEIVING;
            end
         end
         ST_RECEIVING: begin
            rx_reset = 1'b0;
            if (lockout) begin
               push_req   = 1'b1;
               push_entry = {TYPE_ERROR, ABORT_CODE};
               next_state = ST_DISABLED;
            end else if (rx_error) begin
               push_req   = 1'b1;
               push_entry = {TYPE_ERROR, rx_data};
               next_state = ST_RESETTING;
            end else begin
               // A word strobed on the same cycle rx_active falls still belongs to the frame.
               if (!rx_active)
                  next_state = ST_TERMINATE;
               if (rx_strobe) begin
                  push_req   = 1'b1;
                  push_data  = 1'b1;
                  push_entry = {TYPE_DATA, rx_data};
                  count_inc  = 1'b1;
               end
            end
         end
         ST_TERMINATE: begin
            rx_reset   = 1'b0;
            push_req   = 1'b1;
            push_entry = {frame_lost ? TYPE_OVF_EOF : TYPE_EOF, word_cnt};
            next_state = ST_IDLE;
         end
         default: next_state = ST_DISABLED;
      endcase
   end

   // DATA leaves the last free slot for the frame terminator.
   assign accept = push_req &&
                   (fifo_count <= (push_data ? CW'(DEPTH - 2) : CW'(DEPTH - 1)));
   assign drop   = push_req && !accept;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_DISABLED;
         rst_cnt    <= '0;
         word_cnt   <= '0;
         frame_lost <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state <= next_state;
         if (next_state == ST_RESETTING && state != ST_RESETTING)
            rst_cnt <= RW'(RESET_CYCLES - 1);
         else if (state == ST_RESETTING && rst_cnt != '0)
            rst_cnt <= rst_cnt - RW'(1);
         if (start_frame) begin
            word_cnt   <= '0;
            frame_lost <= 1'b0;
         end else begin
            if (count_inc)
               word_cnt <= sat_inc(word_cnt);
            if (drop && push_data)
               frame_lost <= 1'b1;
         end
         if (drop)
            overflow <= 1'b1;
         else if (overflow_clear)
            overflow <= 1'b0;
      end
   end

   coax_fifo #(
      .WIDTH (12),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (accept),
      .pop      (out_read),
      .data_in  (push_entry),
      .data_out (out_data),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_coax_rx_ctrl.sv
// tb/tb_coax_rx_ctrl.sv - randomized self-checking bench for coax_rx_ctrl against a queue-based reference model
module tb_coax_rx_ctrl;

   localparam int         DEPTH        = 16;
   localparam int         RESET_CYCLES = 4;
   localparam logic [9:0] ABORT        = 10'h200;
   localparam logic [1:0] T_DATA = 2'b00, T_EOF = 2'b01, T_ERR = 2'b10, T_OVF = 2'b11;

   logic        clk = 1'b0;
   logic        reset_n, enable, tx_active, rx_reset, rx_active, rx_error, rx_strobe;
   logic [9:0]  rx_data;
   logic [11:0] out_data;
   logic        out_valid, out_read, overflow, overflow_clear;
   logic [4:0]  fifo_count;

   int          checks = 0;
   int          failures = 0;
   logic [11:0] exp_q[$];
   logic [11:0] got_q[$];
   logic [9:0]  words[$];
   bit          exp_ovf;
   bit          lost;
   int          wcount;

   always #5 clk = ~clk;

   coax_rx_ctrl #(.DEPTH(DEPTH), .RESET_CYCLES(RESET_CYCLES), .ABORT_CODE(ABORT)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .tx_active(tx_active),
      .rx_reset(rx_reset), .rx_active(rx_active), .rx_error(rx_error),
      .rx_strobe(rx_strobe), .rx_data(rx_data), .out_data(out_data),
      .out_valid(out_valid), .out_read(out_read), .fifo_count(fifo_count),
      .overflow(overflow), .overflow_clear(overflow_clear)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   // Reference: entries land in an ideal queue if the occupancy rule admits them.
   function automatic void model_push(input logic [1:0] t, input logic [9:0] p);
      int limit;
      limit = (t == T_DATA) ? DEPTH - 2 : DEPTH - 1;
      if (exp_q.size() <= limit)
         exp_q.push_back({t, p});
      else begin
         exp_ovf = 1'b1;
         if (t == T_DATA) lost = 1'b1;
      end
   endfunction

   function automatic void model_close();
      model_push(lost ? T_OVF : T_EOF, (wcount > 1023) ? 10'h3FF : 10'(wcount));
   endfunction

   task automatic drain();
      got_q.delete();
      for (int g = 0; g < 4 * DEPTH && out_valid; g++) begin
         got_q.push_back(out_data);
         out_read = 1'b1;
         tick();
      end
      out_read = 1'b0;
   endtask

   task automatic wait_rx_ready(output bit ok);
      ok = 1'b0;
      for (int g = 0; g < 50; g++) begin
         tick();
         if (!rx_reset) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // end_kind: 0 fall after last word, 1 fall with last word, 2 rx_error, 3 enable drop, 4 tx_active
   task automatic run_frame(input int end_kind, input int max_gap, input logic [9:0] code, output bit ok);
      int n;
      int kind;
      n = words.size();
      kind = (end_kind == 1 && n == 0) ? 0 : end_kind;
      ok = 1'b1;
      lost = 1'b0;
      wcount = 0;
      rx_active = 1'b1;
      tick();
      for (int i = 0; i < n; i++) begin
         rx_strobe = 1'b1;
         rx_data = words[i];
         wcount++;
         model_push(T_DATA, words[i]);
         if (kind == 1 && i == n - 1) rx_active = 1'b0;
         tick();
         rx_strobe = 1'b0;
         rx_data = 10'($urandom);
         if (!(kind == 1 && i == n - 1)) repeat ($urandom_range(0, max_gap)) tick();
      end
      case (kind)
         0: begin
            rx_active = 1'b0;
            tick();
            tick();
            model_close();
         end
         1: begin
            tick();
            model_close();
         end
         2: begin
            rx_error = 1'b1;
            rx_data = code;
            tick();
            rx_error = 1'b0;
            rx_active = 1'b0;
            model_push(T_ERR, code);
            wait_rx_ready(ok);
         end
         default: begin
            if (kind == 3) enable = 1'b0; else tx_active = 1'b1;
            tick();
            rx_active = 1'b0;
            enable = 1'b1;
            tx_active = 1'b0;
            model_push(T_ERR, ABORT);
            wait_rx_ready(ok);
         end
      endcase
   endtask

   task automatic test_reset();
      int hi;
      reset_n = 1'b0; enable = 1'b1; tx_active = 1'b0; rx_active = 1'b0; rx_error = 1'b0;
      rx_strobe = 1'b0; rx_data = '0; out_read = 1'b0; overflow_clear = 1'b0;
      repeat (3) tick();
      checks++; if (rx_reset !== 1'b1) begin failures++; $display("FAIL reset_rx_reset: got %b expected 1", rx_reset); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (fifo_count !== 5'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      reset_n = 1'b1;
      hi = 0;
      for (int g = 0; g < 50; g++) begin
         tick();
         if (!rx_reset) break;
         hi++;
      end
      checks++; if (hi != RESET_CYCLES) begin failures++; $display("FAIL reset_pulse: got %0d cycles expected %0d", hi, RESET_CYCLES); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_idle_valid: got %b expected 0", out_valid); end
      exp_q.delete();
      exp_ovf = 1'b0;
   endtask

   task automatic test_frame_basic();
      bit ok;
      words = '{10'h001, 10'h155, 10'h3FF};
      run_frame(0, 2, 10'h0, ok);
      checks++; if (fifo_count !== 5'(exp_q.size())) begin failures++; $display("FAIL basic_count: got %0d expected %0d", fifo_count, exp_q.size()); end
      checks++; if (overflow !== exp_ovf) begin failures++; $display("FAIL basic_overflow: got %b expected %b", overflow, exp_ovf); end
      drain();
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL basic_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL basic_entry[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
      exp_q.delete();
   endtask

   task automatic test_coincident();
      logic [9:0] w0, w1;
      w0 = 10'($urandom);
      w1 = 10'($urandom);
      lost = 1'b0;
      rx_active = 1'b1; tick();
      rx_strobe = 1'b1; rx_data = w0; tick();
      rx_strobe = 1'b0; tick();
      rx_strobe = 1'b1; rx_data = w1; rx_active = 1'b0; tick();
      rx_strobe = 1'b0;
      model_push(T_DATA, w0); model_push(T_DATA, w1);
      checks++; if (fifo_count !== 5'd2) begin failures++; $display("FAIL coinc_count_data: got %0d expected 2", fifo_count); end
      tick();
      wcount = 2; model_close();
      checks++; if (fifo_count !== 5'd3) begin failures++; $display("FAIL coinc_count_eof: got %0d expected 3", fifo_count); end
      tick();
      drain();
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL coinc_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL coinc_entry[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
      exp_q.delete();
   endtask

   task automatic test_error_recovery();
      int hi;
      bit ok;
      rx_active = 1'b1; tick();
      for (int i = 0; i < 2; i++) begin
         rx_strobe = 1'b1; rx_data = 10'($urandom); model_push(T_DATA, rx_data); tick();
         rx_strobe = 1'b0;
      end
      rx_error = 1'b1; rx_data = 10'h002; tick();
      rx_error = 1'b0; rx_active = 1'b0;
      model_push(T_ERR, 10'h002);
      hi = 0;
      for (int g = 0; g < 50; g++) begin
         if (!rx_reset) break;
         hi++;
         tick();
      end
      checks++; if (hi != RESET_CYCLES) begin failures++; $display("FAIL err_pulse: got %0d cycles expected %0d", hi, RESET_CYCLES); end
      words = '{10'($urandom), 10'($urandom), 10'($urandom)};
      run_frame(0, 1, 10'h0, ok);
      drain();
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL err_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL err_entry[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
      exp_q.delete();
   endtask

   task automatic test_overflow();
      bit ok;
      words.delete();
      for (int i = 0; i < 20; i++) words.push_back(10'($urandom));
      run_frame(0, 0, 10'h0, ok);
      checks++; if (fifo_count !== 5'(exp_q.size())) begin failures++; $display("FAIL ovf_count: got %0d expected %0d", fifo_count, exp_q.size()); end
      checks++; if (overflow !== exp_ovf) begin failures++; $display("FAIL ovf_flag: got %b expected %b", overflow, exp_ovf); end
      overflow_clear = 1'b1; tick(); overflow_clear = 1'b0;
      exp_ovf = 1'b0;
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
      drain();
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL ovf_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_entry[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
      exp_q.delete();
   endtask

   task automatic test_saturate();
      lost = 1'b0; wcount = 0;
      rx_active = 1'b1; tick();
      for (int i = 0; i < 1030; i++) begin
         rx_strobe = 1'b1; rx_data = 10'($urandom);
         model_push(T_DATA, rx_data); wcount++;
         if (i == 1029) overflow_clear = 1'b1;
         tick();
      end
      rx_strobe = 1'b0; overflow_clear = 1'b0;
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL sat_set_wins: got %b expected 1", overflow); end
      rx_active = 1'b0; tick(); tick();
      model_close();
      checks++; if (fifo_count !== 5'(exp_q.size())) begin failures++; $display("FAIL sat_count: got %0d expected %0d", fifo_count, exp_q.size()); end
      drain();
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL sat_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL sat_entry[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
      exp_q.delete();
      overflow_clear = 1'b1; tick(); overflow_clear = 1'b0;
      exp_ovf = 1'b0;
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL sat_clear: got %b expected 0", overflow); end
   endtask

   task automatic test_tx_abort();
      int hold, lows, hi;
      rx_active = 1'b1; tick();
      for (int i = 0; i < 4; i++) begin
         rx_strobe = 1'b1; rx_data = 10'($urandom); model_push(T_DATA, rx_data); tick();
         rx_strobe = 1'b0;
      end
      tx_active = 1'b1; tick();
      rx_active = 1'b0;
      model_push(T_ERR, ABORT);
      hold = $urandom_range(3, 8);
      lows = 0;
      for (int g = 0; g < hold; g++) begin
         if (!rx_reset) lows++;
         tick();
      end
      checks++; if (lows != 0) begin failures++; $display("FAIL abort_lockout: got %0d low cycles expected 0", lows); end
      tx_active = 1'b0;
      hi = 0;
      for (int g = 0; g < 50; g++) begin
         tick();
         if (!rx_reset) break;
         hi++;
      end
      checks++; if (hi != RESET_CYCLES) begin failures++; $display("FAIL abort_pulse: got %0d cycles expected %0d", hi, RESET_CYCLES); end
      drain();
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL abort_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL abort_entry[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      int peak;
      peak = 0;
      got_q.delete();
      lost = 1'b0; wcount = 0;
      out_read = 1'b1;
      rx_active = 1'b1; tick();
      for (int i = 0; i < 8; i++) begin
         rx_strobe = 1'b1; rx_data = 10'($urandom);
         model_push(T_DATA, rx_data); wcount++;
         if (i == 7) rx_active = 1'b0;
         tick();
         if (out_valid) got_q.push_back(out_data);
         if (int'(fifo_count) > peak) peak = int'(fifo_count);
      end
      rx_strobe = 1'b0;
      model_close();
      repeat (3) begin
         tick();
         if (out_valid) got_q.push_back(out_data);
         if (int'(fifo_count) > peak) peak = int'(fifo_count);
      end
      out_read = 1'b0;
      checks++; if (peak > 1) begin failures++; $display("FAIL b2b_peak: got %0d expected at most 1", peak); end
      checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_len: got %0d expected %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_entry[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
      exp_q.delete();
   endtask

   task automatic test_random();
      bit ok;
      for (int f = 0; f < 12; f++) begin
         words.delete();
         repeat ($urandom_range(0, 20)) words.push_back(10'($urandom));
         run_frame($urandom_range(0, 4), 2, 10'($urandom), ok);
         checks++; if (!ok) begin failures++; $display("FAIL rnd_ready[%0d]: rx_reset still high after 50 cycles", f); end
         checks++; if (fifo_count !== 5'(exp_q.size())) begin failures++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", f, fifo_count, exp_q.size()); end
         checks++; if (overflow !== exp_ovf) begin failures++; $display("FAIL rnd_overflow[%0d]: got %b expected %b", f, overflow, exp_ovf); end
         if (f == 11 || $urandom_range(0, 2) == 0) begin
            drain();
            checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd_len[%0d]: got %0d expected %0d", f, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
               checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_entry[%0d.%0d]: got %h expected %h", f, i, got_q[i], exp_q[i]); end
            end
            exp_q.delete();
         end
      end
   endtask

   initial begin
      test_reset();
      test_frame_basic();
      test_coincident();
      test_error_recovery();
      test_overflow();
      test_saturate();
      test_tx_abort();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
